dram_backing_store: RTL and testbench

Synthesizable word-addressed backing memory that sits directly downstream of the AXI-to-DRAM slave bridge and consumes its flat memory port (`req`/`we`/`addr`/`be`/`data`). It returns read data exactly one cycle after a request, applies byte-enabled writes, and zero-fills itself after reset before it serves traffic. It also flags out-of-range accesses and keeps saturating read/write access counters for simulation and FPGA statistics.

---
 rtl/dram_store_pkg.sv | 34 +++
 rtl/dram_backing_store_sram_be.sv | 41 ++++
 rtl/dram_backing_store.sv | 163 ++++++++++++++++
 tb/tb_dram_backing_store.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dram_store_pkg.sv
// Shared types and helpers for the DRAM backing store: FSM states, read-data
// source select, the out-of-range fill pattern and address decode functions.
package dram_store_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    // Which register drives rdata_o: reset zero, the RAM read latch, or the OOB pattern.
    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_MEM  = 2'd1,
        RD_OOB  = 2'd2
    } rd_sel_e;

    localparam int unsigned MAX_DATA_WIDTH = 256;
    localparam logic [MAX_DATA_WIDTH-1:0] OOB_PATTERN = {8{32'hDEAD_BEEF}};

    function automatic int unsigned log_nr_bytes(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    // The lower-bound compare guards the subtraction, so addresses below base never wrap into range.
    function automatic logic in_range(input logic [63:0] addr,
                                      input logic [63:0] base,
                                      input logic [63:0] num_words,
                                      input int unsigned log);
        logic [63:0] idx;
        idx = (addr - base) >> log;
        return (addr >= base) && (idx < num_words);
    endfunction

endpackage

// File: rtl/dram_backing_store_sram_be.sv
// Single-port RAM with per-byte write enables and a one-cycle registered read.
// Each byte lane is its own array so block-RAM byte-write inference stays clean.
module sram_be #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 2048,
    parameter int unsigned IDX_WIDTH  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                    clk_i,
    input  logic                    en_i,
    input  logic                    we_i,
    input  logic [IDX_WIDTH-1:0]    addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);

    localparam int unsigned NR_BYTES = DATA_WIDTH / 8;

    generate
        for (genvar gi = 0; gi < NR_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [NUM_WORDS];
            logic [7:0] lane_rd_reg;

            // Read latch only moves on reads, so rdata holds across writes and idle cycles.
            always_ff @(posedge clk_i) begin
                if (en_i) begin
                    if (we_i) begin
                        if (be_i[gi]) begin
                            lane_mem[addr_i] <= wdata_i[gi*8 +: 8];
                        end
                    end else begin
                        lane_rd_reg <= lane_mem[addr_i];
                    end
                end
            end

            assign rdata_o[gi*8 +: 8] = lane_rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dram_backing_store.sv
// Word-addressed backing memory behind the AXI-to-DRAM bridge: zero-fills after
// reset, serves byte-enabled writes and 1-cycle reads, flags errors, counts accesses.
module dram_backing_store
    import dram_store_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_WORDS  = 2048,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    init_done_o,
    output logic                    oob_o,
    output logic [ADDR_WIDTH-1:0]   err_addr_o,
    input  logic                    err_clr_i,
    output logic [31:0]             rd_cnt_o,
    output logic [31:0]             wr_cnt_o
);

    localparam int unsigned LOG_NR_BYTES = log_nr_bytes(DATA_WIDTH);
    localparam int unsigned NR_BYTES     = DATA_WIDTH / 8;
    localparam int unsigned IDX_WIDTH    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE      = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [IDX_WIDTH-1:0]  LAST_WORD = IDX_WIDTH'(NUM_WORDS - 1);
    localparam logic [31:0]           CNT_MAX   = 32'hFFFF_FFFF;

    state_e                  state_reg, state_next;
    logic [IDX_WIDTH-1:0]    init_cnt_reg, init_cnt_next;
    rd_sel_e                 rd_sel_reg, rd_sel_next;
    logic                    oob_reg, oob_next;
    logic [ADDR_WIDTH-1:0]   err_addr_reg, err_addr_next;
    logic [31:0]             rd_cnt_reg, rd_cnt_next;
    logic [31:0]             wr_cnt_reg, wr_cnt_next;

    logic [ADDR_WIDTH-1:0]   idx_full;
    logic                    addr_ok;
    logic                    new_err;
    logic                    ram_en;
    logic                    ram_we;
    logic [IDX_WIDTH-1:0]    ram_addr;
    logic [NR_BYTES-1:0]     ram_be;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign idx_full = (addr_i - BASE) >> LOG_NR_BYTES;
    assign addr_ok  = in_range(64'(addr_i), BASE_ADDR, 64'(NUM_WORDS), LOG_NR_BYTES);

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        rd_sel_next   = rd_sel_reg;
        oob_next      = oob_reg;
        err_addr_next = err_addr_reg;
        rd_cnt_next   = rd_cnt_reg;
        wr_cnt_next   = wr_cnt_reg;
        new_err       = 1'b0;
        ram_en        = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = IDX_WIDTH'(idx_full);
        ram_be        = be_i;
        ram_wdata     = wdata_i;

        case (state_reg)
            INIT: begin
                // Zero-fill owns the RAM port; any bus request is dropped and flagged.
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = init_cnt_reg;
                ram_be    = '1;
                ram_wdata = '0;
                new_err   = req_i;
                if (init_cnt_reg == LAST_WORD) begin
                    state_next = READY;
                end else begin
                    init_cnt_next = init_cnt_reg + 1'b1;
                end
            end
            READY: begin
                if (req_i) begin
                    if (addr_ok) begin
                        ram_en = 1'b1;
                        ram_we = we_i;
                        if (we_i) begin
                            if (wr_cnt_reg != CNT_MAX) wr_cnt_next = wr_cnt_reg + 1'b1;
                        end else begin
                            rd_sel_next = RD_MEM;
                            if (rd_cnt_reg != CNT_MAX) rd_cnt_next = rd_cnt_reg + 1'b1;
                        end
                    end else begin
                        new_err = 1'b1;
                        if (!we_i) rd_sel_next = RD_OOB;
                    end
                end
            end
            default: state_next = INIT;
        endcase

        // A fresh error beats a simultaneous clear; otherwise the first error is kept.
        if (new_err && (!oob_reg || err_clr_i)) begin
            oob_next      = 1'b1;
            err_addr_next = addr_i;
        end else if (err_clr_i) begin
            oob_next      = 1'b0;
            err_addr_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
            rd_sel_reg   <= RD_ZERO;
            oob_reg      <= 1'b0;
            err_addr_reg <= '0;
            rd_cnt_reg   <= '0;
            wr_cnt_reg   <= '0;
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
            rd_sel_reg   <= rd_sel_next;
            oob_reg      <= oob_next;
            err_addr_reg <= err_addr_next;
            rd_cnt_reg   <= rd_cnt_next;
            wr_cnt_reg   <= wr_cnt_next;
        end
    end

    sram_be #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .IDX_WIDTH  (IDX_WIDTH)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .be_i    (ram_be),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        case (rd_sel_reg)
            RD_MEM:  rdata_o = ram_rdata;
            RD_OOB:  rdata_o = OOB_PATTERN[DATA_WIDTH-1:0];
            default: rdata_o = '0;
        endcase
    end

    assign init_done_o = (state_reg == READY);
    assign oob_o       = oob_reg;
    assign err_addr_o  = err_addr_reg;
    assign rd_cnt_o    = rd_cnt_reg;
    assign wr_cnt_o    = wr_cnt_reg;

endmodule

// File: tb/tb_dram_backing_store.sv
// Directed bench for dram_backing_store with a 16-word store: zero-fill timing,
// byte-enabled writes, range errors, held requests and reset during zero-fill.
module tb_dram_backing_store;

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned NW = 16;
    localparam logic [63:0] OOB = 64'hDEAD_BEEF_DEAD_BEEF;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          req_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [7:0]    be_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic          init_done_o;
    logic          oob_o;
    logic [AW-1:0] err_addr_o;
    logic          err_clr_i;
    logic [31:0]   rd_cnt_o;
    logic [31:0]   wr_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    dram_backing_store #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_WORDS  (NW),
        .BASE_ADDR  (64'h8000_0000)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .init_done_o (init_done_o),
        .oob_o       (oob_o),
        .err_addr_o  (err_addr_o),
        .err_clr_i   (err_clr_i),
        .rd_cnt_o    (rd_cnt_o),
        .wr_cnt_o    (wr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Inputs change at the falling edge; outputs are observed at the next falling edge.
    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic access(input logic we, input logic [63:0] addr,
                          input logic [7:0] be, input logic [63:0] wd);
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        be_i    = be;
        wdata_i = wd;
        cycle();
        req_i   = 1'b0;
        we_i    = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rdata"},    rdata_o,           64'h0);
        check({tag, "_done"},     64'(init_done_o),  64'h0);
        check({tag, "_oob"},      64'(oob_o),        64'h0);
        check({tag, "_err_addr"}, err_addr_o,        64'h0);
        check({tag, "_rd_cnt"},   64'(rd_cnt_o),     64'h0);
        check({tag, "_wr_cnt"},   64'(wr_cnt_o),     64'h0);
    endtask

    initial begin
        rst_ni    = 1'b0;
        req_i     = 1'b0;
        we_i      = 1'b0;
        addr_i    = '0;
        be_i      = '0;
        wdata_i   = '0;
        err_clr_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check_reset_values("rst");

        // Zero-fill: done rises on the 16th rising edge after release.
        rst_ni = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            cycle();
            check($sformatf("init_done_e%0d", i), 64'(init_done_o), (i == 16) ? 64'h1 : 64'h0);
        end

        for (int i = 0; i < 16; i++) begin
            access(1'b0, 64'h8000_0000 + 64'(i * 8), 8'h00, 64'h0);
            check($sformatf("zero_rd_w%0d", i), rdata_o, 64'h0);
        end
        check("rd_cnt_after_scan", 64'(rd_cnt_o), 64'd16);
        check("wr_cnt_after_scan", 64'(wr_cnt_o), 64'd0);

        access(1'b1, 64'h8000_0008, 8'hFF, 64'h1122_3344_5566_7788);
        access(1'b1, 64'h8000_0008, 8'h0F, 64'hAAAA_AAAA_AAAA_AAAA);
        access(1'b0, 64'h8000_0008, 8'h00, 64'h0);
        check("be_low_merge", rdata_o, 64'h1122_3344_AAAA_AAAA);
        check("wr_cnt_2", 64'(wr_cnt_o), 64'd2);
        access(1'b1, 64'h8000_0078, 8'hF0, 64'hCAFE_BABE_1234_5678);
        access(1'b0, 64'h8000_0078, 8'h00, 64'h0);
        check("be_high_last_word", rdata_o, 64'hCAFE_BABE_0000_0000);
        access(1'b1, 64'h8000_0010, 8'hFF, 64'h5555_5555_5555_5555);
        check("rdata_hold_on_write", rdata_o, 64'hCAFE_BABE_0000_0000);
        access(1'b1, 64'h8000_0008, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF);
        check("be_zero_counts", 64'(wr_cnt_o), 64'd5);
        access(1'b0, 64'h8000_0008, 8'h00, 64'h0);
        check("be_zero_noop", rdata_o, 64'h1122_3344_AAAA_AAAA);
        check("rd_cnt_19", 64'(rd_cnt_o), 64'd19);

        access(1'b0, 64'h7FFF_FFF8, 8'h00, 64'h0);
        check("oob_below_rdata", rdata_o, OOB);
        check("oob_below_flag", 64'(oob_o), 64'h1);
        check("oob_below_addr", err_addr_o, 64'h7FFF_FFF8);
        access(1'b0, 64'h8000_0080, 8'h00, 64'h0);
        check("oob_above_rdata", rdata_o, OOB);
        check("oob_first_kept", err_addr_o, 64'h7FFF_FFF8);
        check("oob_rd_cnt_same", 64'(rd_cnt_o), 64'd19);
        access(1'b1, 64'h8000_0080, 8'hFF, 64'h0123_4567_89AB_CDEF);
        check("oob_wr_cnt_same", 64'(wr_cnt_o), 64'd5);
        access(1'b0, 64'h8000_0078, 8'h00, 64'h0);
        check("rd_after_oob", rdata_o, 64'hCAFE_BABE_0000_0000);

        // Held request: every cycle is a fresh, counted read.
        for (int i = 0; i < 5; i++) begin
            access(1'b0, 64'h8000_0008, 8'h00, 64'h0);
            check($sformatf("held_rd_%0d", i), rdata_o, 64'h1122_3344_AAAA_AAAA);
        end
        check("held_rd_cnt", 64'(rd_cnt_o), 64'd25);

        err_clr_i = 1'b1;
        access(1'b0, 64'h8000_0100, 8'h00, 64'h0);
        err_clr_i = 1'b0;
        check("clr_vs_err_flag", 64'(oob_o), 64'h1);
        check("clr_vs_err_addr", err_addr_o, 64'h8000_0100);
        check("clr_vs_err_rdata", rdata_o, OOB);
        err_clr_i = 1'b1;
        cycle();
        err_clr_i = 1'b0;
        check("clr_flag", 64'(oob_o), 64'h0);
        check("clr_addr", err_addr_o, 64'h0);

        // Reset during traffic, then again at cycle 7 of the zero-fill.
        rst_ni = 1'b0;
        cycle();
        check_reset_values("rst2");
        rst_ni = 1'b1;
        repeat (7) cycle();
        check("mid_init_not_done", 64'(init_done_o), 64'h0);
        rst_ni = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        check("mid_init_rst_done", 64'(init_done_o), 64'h0);
        rst_ni = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin
                access(1'b1, 64'h8000_0000, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
                check("init_drop_oob", 64'(oob_o), 64'h1);
                check("init_drop_addr", err_addr_o, 64'h8000_0000);
                check("init_drop_wr_cnt", 64'(wr_cnt_o), 64'd0);
            end else begin
                cycle();
            end
            check($sformatf("reinit_done_e%0d", i), 64'(init_done_o), (i == 16) ? 64'h1 : 64'h0);
        end
        access(1'b0, 64'h8000_0000, 8'h00, 64'h0);
        check("init_drop_word0", rdata_o, 64'h0);
        access(1'b0, 64'h8000_0078, 8'h00, 64'h0);
        check("refill_word15", rdata_o, 64'h0);
        access(1'b0, 64'h8000_0008, 8'h00, 64'h0);
        check("refill_word1", rdata_o, 64'h0);
        check("refill_rd_cnt", 64'(rd_cnt_o), 64'd3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
